// File: rtl/inv_shift_rows_round_engine_pkg.sv
// Shared AES-128 decrypt types, FSM encoding and the InvShiftRows / InvMixColumns
// helpers used by the iterative inverse round engine.
package inv_shift_rows_round_engine_pkg;

   localparam int unsigned AES128_ROUNDS = 10;
   localparam int unsigned BLK_W         = 128;
   localparam int unsigned KIDX_W        = 4;

   typedef logic [7:0]   byte_t;
   typedef byte_t [15:0] block_t;   // byte0 lives in [15] (bits 127:120)

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } state_e;

   // Row r rotated right by r; byte n sits at packed index 15-n
   function automatic block_t inv_shift_rows(input block_t s);
      block_t r;
      for (int unsigned col = 0; col < 4; col++) begin
         for (int unsigned row = 0; row < 4; row++) begin
            r[4'(15 - 4*col - row)] = s[4'(15 - 4*((col + 4 - row) % 4) - row)];
         end
      end
      return r;
   endfunction

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant as a sum of xtime powers
   function automatic byte_t gf_mul_k(input byte_t b, input logic [3:0] k);
      byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
             (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      byte_t a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mul_k(a0, 4'he) ^ gf_mul_k(a1, 4'hb) ^ gf_mul_k(a2, 4'hd) ^ gf_mul_k(a3, 4'h9),
              gf_mul_k(a0, 4'h9) ^ gf_mul_k(a1, 4'he) ^ gf_mul_k(a2, 4'hb) ^ gf_mul_k(a3, 4'hd),
              gf_mul_k(a0, 4'hd) ^ gf_mul_k(a1, 4'h9) ^ gf_mul_k(a2, 4'he) ^ gf_mul_k(a3, 4'hb),
              gf_mul_k(a0, 4'hb) ^ gf_mul_k(a1, 4'hd) ^ gf_mul_k(a2, 4'h9) ^ gf_mul_k(a3, 4'he)};
   endfunction

   function automatic block_t inv_mix_columns(input block_t s);
      block_t r;
      for (int unsigned c = 0; c < 4; c++) begin
         r[4'(15 - 4*c) -: 4] = inv_mix_column(s[4'(15 - 4*c) -: 4]);
      end
      return r;
   endfunction

endpackage

// File: rtl/inv_shift_rows_round_engine_if.sv
// Block in / key index / plaintext out bundle of the inverse round engine.
// slave = engine side, master = feeder, key store and consumer side.
interface inv_shift_rows_round_engine_if;
   import inv_shift_rows_round_engine_pkg::*;

   logic              i_valid;
   logic              o_ready;
   logic [BLK_W-1:0]  i_data;
   logic [KIDX_W-1:0] o_key_idx;
   logic [BLK_W-1:0]  i_round_key;
   logic              o_valid;
   logic              i_ready;
   logic [BLK_W-1:0]  o_data;

   modport slave (
      input  i_valid, i_data, i_round_key, i_ready,
      output o_ready, o_key_idx, o_valid, o_data
   );

   modport master (
      output i_valid, i_data, i_round_key, i_ready,
      input  o_ready, o_key_idx, o_valid, o_data
   );
endinterface

// File: rtl/inv_shift_rows_round_engine_inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry byte lookup.
module inv_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   localparam logic [7:0] LUT [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign o_byte = LUT[i_byte];
endmodule

// File: rtl/inv_shift_rows_round_engine.sv
// Iterative AES-128 inverse cipher: one InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns
// round per clock, round keys fetched combinationally through o_key_idx.
module inv_shift_rows_round_engine
   import inv_shift_rows_round_engine_pkg::*;
#(
   parameter int unsigned NROUNDS = 10
) (
   input logic                          clk,
   input logic                          rst,
   inv_shift_rows_round_engine_if.slave io_bus
);

   if (NROUNDS != AES128_ROUNDS) begin : g_bad_nrounds
      $error("inv_shift_rows_round_engine supports only NROUNDS = 10");
   end

   state_e            r_state, w_state_nxt;
   logic [3:0]        r_ctr, w_ctr_nxt;
   block_t            r_blk, w_blk_nxt;
   logic [BLK_W-1:0]  r_data, w_data_nxt;
   logic              r_valid, w_valid_nxt;
   logic              w_ready;
   logic [KIDX_W-1:0] w_key_idx;
   block_t            w_isr, w_isb;

   // InvShiftRows then InvSubBytes, shared by ROUND and FINAL
   assign w_isr = inv_shift_rows(r_blk);

   for (genvar g = 0; g < 16; g++) begin : g_sbox
      inv_sbox u_inv_sbox (
         .i_byte (w_isr[g]),
         .o_byte (w_isb[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ctr   <= 4'(AES128_ROUNDS - 1);
         r_blk   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ctr   <= w_ctr_nxt;
         r_blk   <= w_blk_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   // Block register only loads on accept or a live round, so an idle key bus never leaks in
   always_comb begin
      w_state_nxt = r_state;
      w_ctr_nxt   = r_ctr;
      w_blk_nxt   = r_blk;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_ready     = 1'b0;
      w_key_idx   = KIDX_W'(AES128_ROUNDS);

      unique case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (io_bus.i_valid) begin
               w_blk_nxt   = io_bus.i_data ^ io_bus.i_round_key;
               w_ctr_nxt   = 4'(AES128_ROUNDS - 1);
               w_state_nxt = ST_ROUND;
            end
         end
         ST_ROUND: begin
            w_key_idx = r_ctr;
            w_blk_nxt = inv_mix_columns(w_isb ^ io_bus.i_round_key);
            w_ctr_nxt = r_ctr - 4'd1;
            if (r_ctr == 4'd1) begin
               w_state_nxt = ST_FINAL;
            end
         end
         ST_FINAL: begin
            w_key_idx   = '0;
            w_data_nxt  = w_isb ^ io_bus.i_round_key;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (io_bus.i_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign io_bus.o_ready   = w_ready & ~rst;
   assign io_bus.o_key_idx = w_key_idx;
   assign io_bus.o_valid   = r_valid;
   assign io_bus.o_data    = r_data;

endmodule

// File: tb/tb_inv_shift_rows_round_engine.sv
// Bench for the AES-128 inverse round engine: known-answer table, key index sequence,
// backpressure, back-to-back, reset and random round trips against an encrypt model.
module tb_inv_shift_rows_round_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inv_shift_rows_round_engine_if bus ();

   inv_shift_rows_round_engine #(.NROUNDS(10)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc_edge = 0;
   logic prev_valid = 1'b0;

   logic [7:0]   sb [256];
   logic [127:0] rk_next [16];
   logic [127:0] rk_act  [16];
   logic [127:0] cur_exp;
   logic [127:0] exp_q [$];
   int           acc_q [$];
   int           hs_q  [$];

   typedef struct {
      string        nm;
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;
   vec_t vecs [3];

   always @(posedge clk) cyc <= cyc + 1;

   // Key store: pending key while idle, in-flight key once accepted
   always_comb begin
      if (bus.o_ready) bus.i_round_key = rk_next[10];
      else             bus.i_round_key = rk_act[bus.o_key_idx];
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // Forward S-box from GF(2^8) inverse (x^254) plus the affine map
   function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
      logic [7:0] p, y;
      p = x;
      y = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gm(p, p);
         y = gm(y, p);
      end
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   task automatic set_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_next[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [127:0] s;
      s = pt ^ rk_next[0];
      for (int r = 1; r <= 10; r++) begin
         for (int n = 0; n < 16; n++) a[n] = sb[s[8*(15-n) +: 8]];
         for (int n = 0; n < 16; n++) t[n] = a[4*(((n/4) + (n%4)) % 4) + (n%4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               a[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
               a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
               a[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
            end
         end else begin
            a = t;
         end
         for (int n = 0; n < 16; n++) s[8*(15-n) +: 8] = a[n];
         s = s ^ rk_next[r];
      end
      return s;
   endfunction

   // Scoreboard: push on accept, pop on output handshake
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.i_valid && bus.o_ready) begin
            exp_q.push_back(cur_exp);
            acc_edge = cyc + 1;
            acc_q.push_back(cyc + 1);
            rk_act = rk_next;
         end
         if (bus.o_valid && !prev_valid) chk("latency", 128'(cyc - acc_edge), 128'd10);
         if (bus.o_valid && bus.i_ready) begin
            hs_q.push_back(cyc + 1);
            if (exp_q.size() == 0) chk("unexpected_out", 128'(bus.o_valid), 128'd0);
            else                   chk("plaintext", bus.o_data, exp_q.pop_front());
         end
      end
      prev_valid = rst ? 1'b0 : bus.o_valid;
   end

   task automatic drive(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
      set_key(key);
      bus.i_data  = ct;
      cur_exp     = pt;
      bus.i_valid = 1'b1;
   endtask

   task automatic wait_accept(input bit keep);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.o_ready;
      end
      @(posedge clk);
      #1;
      if (!keep) bus.i_valid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: o_ready never rose (t=%0t)", $time);
      end
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         ok = (exp_q.size() == 0) && bus.o_ready;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d blocks outstanding", exp_q.size());
      end
   endtask

   task automatic wait_out_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.o_valid;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL valid_timeout: o_valid never rose");
      end
   endtask

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   initial begin
      logic [127:0] k, p;
      int a_last, a_prev;

      for (int x = 0; x < 256; x++) sb[x] = fwd_sbox(8'(x));
      for (int r = 0; r < 16; r++) begin
         rk_next[r] = '0;
         rk_act[r]  = '0;
      end
      vecs[0].nm = "fips_c1";   vecs[0].key = C1_KEY; vecs[0].ct = C1_CT; vecs[0].pt = C1_PT;
      vecs[1].nm = "fips_b";    vecs[1].key = B_KEY;  vecs[1].ct = B_CT;  vecs[1].pt = B_PT;
      vecs[2].nm = "zero_key";  vecs[2].key = '0;
      vecs[2].ct = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e; vecs[2].pt = '0;

      rst = 1'b1; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b1; cur_exp = '0;

      // Reset state
      @(negedge clk);
      chk("rst_ready",   128'(bus.o_ready),   128'd0);
      chk("rst_valid",   128'(bus.o_valid),   128'd0);
      chk("rst_data",    bus.o_data,          128'd0);
      chk("rst_key_idx", 128'(bus.o_key_idx), 128'd10);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_ready", 128'(bus.o_ready), 128'd1);

      // Key index sequence 10,9..1,0 on FIPS-197 B
      @(posedge clk); #1;
      drive(B_KEY, B_CT, B_PT);
      @(negedge clk);
      chk("key_idx_idle", 128'(bus.o_key_idx), 128'd10);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      for (int e = 9; e >= 0; e--) begin
         @(negedge clk);
         chk($sformatf("key_idx_%0d", e), 128'(bus.o_key_idx), 128'(e));
      end
      wait_drain();

      // Known-answer table
      for (int v = 0; v < 3; v++) begin
         @(posedge clk); #1;
         drive(vecs[v].key, vecs[v].ct, vecs[v].pt);
         wait_accept(1'b0);
         wait_drain();
      end

      // Back-to-back with i_valid held high
      @(posedge clk); #1;
      drive(C1_KEY, C1_CT, C1_PT);
      wait_accept(1'b1);
      drive(C1_KEY, C1_CT, C1_PT);
      wait_accept(1'b0);
      wait_drain();
      a_last = acc_q[acc_q.size()-1];
      a_prev = acc_q[acc_q.size()-2];
      chk("b2b_spacing", 128'(a_last - a_prev), 128'd12);

      // Backpressure: 20-cycle stall in DONE with a second block waiting
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      drive(B_KEY, B_CT, B_PT);
      wait_accept(1'b0);
      wait_out_valid();
      @(posedge clk); #1;
      drive(C1_KEY, C1_CT, C1_PT);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_data", bus.o_data, B_PT);
         chk("bp_valid_ready", 128'({bus.o_valid, bus.o_ready}), 128'b10);
      end
      @(posedge clk); #1;
      bus.i_ready = 1'b1;
      wait_accept(1'b0);
      chk("bp_accept_gap", 128'(acc_q[acc_q.size()-1] - hs_q[hs_q.size()-1]), 128'd1);
      wait_drain();

      // Reset during ROUND with ctr = 5
      @(posedge clk); #1;
      drive(C1_KEY, C1_CT, C1_PT);
      wait_accept(1'b0);
      for (int i = 0; i < 20 && bus.o_key_idx != 4'd5; i++) @(negedge clk);
      chk("mid_ctr", 128'(bus.o_key_idx), 128'd5);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 128'(bus.o_valid), 128'd0);
      chk("mid_rst_ready", 128'(bus.o_ready), 128'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", 128'(bus.o_ready), 128'd1);
      chk("rel_valid", 128'(bus.o_valid), 128'd0);
      chk("rel_key_idx", 128'(bus.o_key_idx), 128'd10);
      @(posedge clk); #1;
      drive(C1_KEY, C1_CT, C1_PT);
      wait_accept(1'b0);
      wait_drain();

      // Reset while stalled in DONE drops o_valid at once
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      drive(B_KEY, B_CT, B_PT);
      wait_accept(1'b0);
      wait_out_valid();
      #2 rst = 1'b1;
      #1;
      chk("done_rst_valid", 128'(bus.o_valid), 128'd0);
      chk("done_rst_data", bus.o_data, 128'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.i_ready = 1'b1;

      // Random round trips through the encrypt model
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         p = {$urandom(), $urandom(), $urandom(), $urandom()};
         set_key(k);
         drive(k, aes_enc(p), p);
         wait_accept(1'b0);
      end
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
